// File: rtl/pong_gfx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : pong_gfx_pkg                                                   |
// | Purpose   : Shared constants and types for the Pong bitmap graphics path   |
// |             (screen geometry, coordinate widths, colours, draw states).    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package pong_gfx_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOR_W  = 3;

  // Colour encoding is {R,G,B}
  localparam logic [COLOR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOR_W-1:0] RED     = 3'b100;
  localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOR_W-1:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rect_fill_engine                                               |
// | Purpose   : Accepts one rectangle command and emits one clipped pixel      |
// |             write per cycle in raster order for the bitmap frame buffer.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rect_fill_engine #(
  parameter int SCREEN_W = pong_gfx_pkg::SCREEN_W,
  parameter int SCREEN_H = pong_gfx_pkg::SCREEN_H,
  parameter int X_W      = pong_gfx_pkg::X_W,
  parameter int Y_W      = pong_gfx_pkg::Y_W,
  parameter int COLOR_W  = pong_gfx_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               wr_en
);

  import pong_gfx_pkg::*;

  // Screen limits widened by one bit so the origin+size sums can be compared unwrapped
  localparam logic [X_W:0] c_x_lim = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] c_y_lim = (Y_W+1)'(SCREEN_H);

  draw_state_t        r_state;
  logic [X_W-1:0]     r_x0;
  logic [X_W-1:0]     r_x_end;
  logic [Y_W-1:0]     r_y_end;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COLOR_W-1:0] r_color;
  logic               r_busy;
  logic               r_done;
  logic               r_wr_en;

  logic [X_W:0]       w_x_sum;
  logic [Y_W:0]       w_y_sum;
  logic [X_W-1:0]     w_x_end;
  logic [Y_W-1:0]     w_y_end;
  logic               w_empty;
  logic               w_last_col;
  logic               w_last_row;

  // Clip the command against the screen edges (exclusive end coordinates)
  always_comb begin
    w_x_sum    = {1'b0, x0} + {1'b0, width};
    w_y_sum    = {1'b0, y0} + {1'b0, height};
    w_x_end    = (w_x_sum > c_x_lim) ? c_x_lim[X_W-1:0] : w_x_sum[X_W-1:0];
    w_y_end    = (w_y_sum > c_y_lim) ? c_y_lim[Y_W-1:0] : w_y_sum[Y_W-1:0];
    w_empty    = (width == '0) || (height == '0) ||
                 ({1'b0, x0} >= c_x_lim) || ({1'b0, y0} >= c_y_lim);
    w_last_col = ((r_x + 1'b1) == r_x_end);
    w_last_row = ((r_y + 1'b1) == r_y_end);
  end

  // Command acceptance, raster walk and completion pulse; all outputs registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x0    <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x0    <= x0;
            r_x_end <= w_x_end;
            r_y_end <= w_y_end;
            if (w_empty) begin
              // Nothing visible: complete without touching the write port
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAW;
              r_busy  <= 1'b1;
              r_wr_en <= 1'b1;
              r_x     <= x0;
              r_y     <= y0;
              r_color <= color_in;
            end
          end
        end
        DRAW: begin
          if (w_last_col && w_last_row) begin
            // Last pixel has just been presented; x/y/colour hold their values
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_last_col) begin
            r_x <= r_x0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign x     = r_x;
  assign y     = r_y;
  assign color = r_color;
  assign wr_en = r_wr_en;

endmodule
`default_nettype wire
